// File: rtl/ram_responder_if.sv
// ram_responder_if
//   Instruction/data hit-handshake bundle between the datapath and the
//   memory-side responder.
//   master : datapath side, drives requests, addresses, store data and halt.
//   slave  : memory side, returns load words and one-cycle hit pulses.
interface ram_responder_if;
    logic        i_ren;
    logic [31:0] i_addr;
    logic [31:0] i_load;
    logic        i_hit;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_store;
    logic [31:0] d_load;
    logic        d_hit;
    logic        halt;

    modport master (
        output i_ren, i_addr, d_ren, d_wen, d_addr, d_store, halt,
        input  i_load, i_hit, d_load, d_hit
    );

    modport slave (
        input  i_ren, i_addr, d_ren, d_wen, d_addr, d_store, halt,
        output i_load, i_hit, d_load, d_hit
    );
endinterface

// File: rtl/ram_responder.sv
// ram_responder
//   Single-ported word memory answering instruction and data requests with
//   a one-cycle hit pulse LAT+1 cycles after the request is granted from
//   IDLE. Data requests win over instruction fetches. A preload port fills
//   the array while the responder is idle.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   bus (slave)         i_ren/i_addr/i_load/i_hit, d_ren/d_wen/d_addr/
//                       d_store/d_load/d_hit, halt
//   prog_wen/addr/data  preload write port (honoured only in IDLE)
//   busy                registered, high whenever the FSM is not in IDLE
//   err                 sticky access-error flag, cleared only by RST
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accept preload or grant a D (priority) or I request
// WAIT  | count down the latency, abort if the request is withdrawn
// RESP  | hit pulse for the granted requester, then back to IDLE
module ram_responder #(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024
) (
    input  logic            CLK,
    input  logic            RST,
    ram_responder_if.slave  bus,
    input  logic            prog_wen,
    input  logic [31:0]     prog_addr,
    input  logic [31:0]     prog_data,
    output logic            busy,
    output logic            err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'((LAT > 0) ? (LAT - 1) : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic grant;

    logic [31:0] mem [DEPTH];

    // Access attributes captured at grant time.
    logic          is_d_q, wr_q, acc_err_q;
    logic [AW-1:0] widx_q;
    logic [31:0]   store_q;

    // Attributes of the request that would be granted in IDLE this cycle.
    logic          d_req, i_req;
    logic          g_is_d, g_wr, g_err;
    logic [31:0]   g_addr;
    logic [AW-1:0] g_widx;

    // Attributes of the access in flight; with LAT==0 RESP is entered
    // straight from IDLE, before anything has been latched.
    logic          acc_is_d, acc_wr, acc_err;
    logic [AW-1:0] acc_widx;
    logic [31:0]   acc_store;
    logic [31:0]   rd_word;

    logic          drop, enter_resp;
    logic          prog_in_range, prog_we, data_we, mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;

    logic unused_prog_lsbs;
    assign unused_prog_lsbs = &{1'b0, prog_addr[1:0]};

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
    endfunction

    always_comb begin
        d_req    = bus.d_ren | bus.d_wen;
        i_req    = bus.i_ren & ~bus.halt;
        g_is_d   = d_req;
        g_addr   = d_req ? bus.d_addr : bus.i_addr;
        g_wr     = d_req & bus.d_wen;
        // ren & wen together is handled as a write that never commits.
        g_err    = addr_bad(g_addr) | (d_req & bus.d_ren & bus.d_wen);
        g_widx   = g_addr[AW+1:2];

        if (state_q == IDLE) begin
            acc_is_d  = g_is_d;
            acc_wr    = g_wr;
            acc_err   = g_err;
            acc_widx  = g_widx;
            acc_store = bus.d_store;
        end else begin
            acc_is_d  = is_d_q;
            acc_wr    = wr_q;
            acc_err   = acc_err_q;
            acc_widx  = widx_q;
            acc_store = store_q;
        end
        rd_word = mem[acc_widx];

        drop = is_d_q ? ~(bus.d_ren | bus.d_wen) : (~bus.i_ren | bus.halt);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!prog_wen && (d_req || i_req)) begin
                    grant = 1'b1;
                    if (LAT == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (drop) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp    = (state_d == RESP) && (state_q != RESP);
    assign prog_in_range = ((prog_addr >> (AW + 2)) == 32'd0);
    assign prog_we       = (state_q == IDLE) & prog_wen & prog_in_range;
    assign data_we       = enter_resp & acc_wr & ~acc_err;
    assign mem_we        = ~RST & (prog_we | data_we);
    assign mem_widx      = prog_we ? prog_addr[AW+1:2] : acc_widx;
    assign mem_wdata     = prog_we ? prog_data : acc_store;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_d_q     <= 1'b0;
            wr_q       <= 1'b0;
            acc_err_q  <= 1'b0;
            widx_q     <= '0;
            store_q    <= '0;
            bus.i_hit  <= 1'b0;
            bus.d_hit  <= 1'b0;
            bus.i_load <= '0;
            bus.d_load <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy      <= (state_d != IDLE);
            if (grant) begin
                is_d_q    <= g_is_d;
                wr_q      <= g_wr;
                acc_err_q <= g_err;
                widx_q    <= g_widx;
                store_q   <= bus.d_store;
            end
            bus.i_hit <= enter_resp & ~acc_is_d;
            bus.d_hit <= enter_resp & acc_is_d;
            if (enter_resp) begin
                if (acc_err) begin
                    err <= 1'b1;
                end
                if (acc_is_d) begin
                    if (acc_err) begin
                        bus.d_load <= '0;
                    end else if (!acc_wr) begin
                        bus.d_load <= rd_word;
                    end
                end else begin
                    bus.i_load <= acc_err ? 32'd0 : rd_word;
                end
            end
        end
    end
endmodule
